// File: rtl/hwag_pkg.sv
// Shared types and constants for the hwag SSRAM path: arbiter FSM states,
// default SSRAM geometry and the port-select encoding.
package hwag_pkg;

   localparam int SSRAM_AW = 8;
   localparam int SSRAM_DW = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      RWAIT = 2'd2,
      ACK   = 2'd3
   } ssram_arb_state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_sel_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last. Purely combinational, one-hot grant.
module arb_rr2
   import hwag_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last == PORT_B) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/ssram_arbiter.sv
// Arbitrates a host port (A) and a core port (B) onto one single-port SSRAM.
// One transaction at a time: IDLE latches a winner, XFER strobes, RWAIT
// covers read latency, ACK pulses the winner's ack.
//
// Handshake: x_req is sampled only in IDLE; once latched the transaction is
// owned by the arbiter and always ends with exactly one x_ack pulse (unless
// reset). x_rdata is valid while x_ack is high and holds until that port's
// next read.
module ssram_arbiter
   import hwag_pkg::*;
#(
   parameter int AW     = SSRAM_AW,
   parameter int DW     = SSRAM_DW,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   output logic          ssram_we,
   output logic          ssram_re,
   output logic [AW-1:0] ssram_addr,
   output logic [DW-1:0] ssram_wdata,
   input  logic [DW-1:0] ssram_rdata,
   output logic [1:0]    dbg_state_o
);

   // RWAIT spans RD_LAT-1 cycles; the counter is loaded with one less than that.
   localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

   ssram_arb_state_t state_q, state_d;
   port_sel_t        win_q, win_d;
   port_sel_t        last_q, last_d;
   logic             we_q, we_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             ssram_we_q, ssram_we_d;
   logic             ssram_re_q, ssram_re_d;
   logic [AW-1:0]    ssram_addr_q, ssram_addr_d;
   logic [DW-1:0]    ssram_wdata_q, ssram_wdata_d;
   logic             a_ack_q, a_ack_d;
   logic             b_ack_q, b_ack_d;
   logic [DW-1:0]    a_rdata_q, a_rdata_d;
   logic [DW-1:0]    b_rdata_q, b_rdata_d;
   logic [1:0]       grant;
   logic             capture;

   arb_rr2 u_arb (
      .req   ({b_req, a_req}),
      .last  (last_q),
      .grant (grant)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         win_q         <= PORT_A;
         last_q        <= PORT_B;
         we_q          <= 1'b0;
         cnt_q         <= 2'd0;
         ssram_we_q    <= 1'b0;
         ssram_re_q    <= 1'b0;
         ssram_addr_q  <= '0;
         ssram_wdata_q <= '0;
         a_ack_q       <= 1'b0;
         b_ack_q       <= 1'b0;
         a_rdata_q     <= '0;
         b_rdata_q     <= '0;
      end else begin
         state_q       <= state_d;
         win_q         <= win_d;
         last_q        <= last_d;
         we_q          <= we_d;
         cnt_q         <= cnt_d;
         ssram_we_q    <= ssram_we_d;
         ssram_re_q    <= ssram_re_d;
         ssram_addr_q  <= ssram_addr_d;
         ssram_wdata_q <= ssram_wdata_d;
         a_ack_q       <= a_ack_d;
         b_ack_q       <= b_ack_d;
         a_rdata_q     <= a_rdata_d;
         b_rdata_q     <= b_rdata_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      win_d         = win_q;
      last_d        = last_q;
      we_d          = we_q;
      cnt_d         = cnt_q;
      ssram_we_d    = 1'b0;
      ssram_re_d    = 1'b0;
      ssram_addr_d  = ssram_addr_q;
      ssram_wdata_d = ssram_wdata_q;
      a_rdata_d     = a_rdata_q;
      b_rdata_d     = b_rdata_q;
      capture       = 1'b0;

      case (state_q)
         IDLE: begin
            // The SSRAM address/data registers double as the transaction latch.
            if (grant[1]) begin
               win_d         = PORT_B;
               we_d          = b_we;
               ssram_addr_d  = b_addr;
               ssram_wdata_d = b_wdata;
               ssram_we_d    = b_we;
               ssram_re_d    = !b_we;
               state_d       = XFER;
            end else if (grant[0]) begin
               win_d         = PORT_A;
               we_d          = a_we;
               ssram_addr_d  = a_addr;
               ssram_wdata_d = a_wdata;
               ssram_we_d    = a_we;
               ssram_re_d    = !a_we;
               state_d       = XFER;
            end
         end
         XFER: begin
            if (we_q) begin
               state_d = ACK;
            end else if (RD_LAT <= 1) begin
               state_d = ACK;
               capture = 1'b1;
            end else begin
               state_d = RWAIT;
               cnt_d   = CNT_INIT;
            end
         end
         RWAIT: begin
            if (cnt_q == 2'd0) begin
               state_d = ACK;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ACK: begin
            last_d  = win_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (capture) begin
         if (win_q == PORT_A) a_rdata_d = ssram_rdata;
         else                 b_rdata_d = ssram_rdata;
      end

      a_ack_d = (state_d == ACK) && (win_d == PORT_A);
      b_ack_d = (state_d == ACK) && (win_d == PORT_B);
   end

   assign ssram_we    = ssram_we_q;
   assign ssram_re    = ssram_re_q;
   assign ssram_addr  = ssram_addr_q;
   assign ssram_wdata = ssram_wdata_q;
   assign a_ack       = a_ack_q;
   assign b_ack       = b_ack_q;
   assign a_rdata     = a_rdata_q;
   assign b_rdata     = b_rdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ssram_arbiter.sv
// Self-checking bench for ssram_arbiter with a registered SSRAM read model
// (RD_LAT=2) and an ack scoreboard of {port, rdata} entries.
`timescale 1ns/1ps
module tb_ssram_arbiter;
   import hwag_pkg::*;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int RD_LAT = 2;
   localparam int W = 1 + DW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          a_req = 1'b0, a_we = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_wdata = '0;
   logic          a_ack;
   logic [DW-1:0] a_rdata;
   logic          b_req = 1'b0, b_we = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic [DW-1:0] b_wdata = '0;
   logic          b_ack;
   logic [DW-1:0] b_rdata;
   logic          ssram_we, ssram_re;
   logic [AW-1:0] ssram_addr;
   logic [DW-1:0] ssram_wdata, ssram_rdata;
   logic [1:0]    dbg_state;
   logic [DW-1:0] rd_pipe;

   int            n_checks = 0;
   int            n_fail = 0;
   logic [W-1:0]  exp_q[$];
   logic [DW-1:0] exp_a_rdata = '0;
   logic [DW-1:0] exp_b_rdata = '0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   ssram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .a_req       (a_req),
      .a_we        (a_we),
      .a_addr      (a_addr),
      .a_wdata     (a_wdata),
      .a_ack       (a_ack),
      .a_rdata     (a_rdata),
      .b_req       (b_req),
      .b_we        (b_we),
      .b_addr      (b_addr),
      .b_wdata     (b_wdata),
      .b_ack       (b_ack),
      .b_rdata     (b_rdata),
      .ssram_we    (ssram_we),
      .ssram_re    (ssram_re),
      .ssram_addr  (ssram_addr),
      .ssram_wdata (ssram_wdata),
      .ssram_rdata (ssram_rdata),
      .dbg_state_o (dbg_state)
   );

   // SSRAM read model: content is a fixed function of address, one pipeline stage.
   function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
      if (a == 8'h34) return 16'h5A5A;
      return {~a, a};
   endfunction

   always @(posedge clk) if (ssram_re) rd_pipe <= model_data(ssram_addr);
   assign ssram_rdata = rd_pipe;

   // ---------------- driver tasks ----------------
   task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
   endtask

   task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive_a(1'b0, 1'b0, '0, '0);
      drive_b(1'b0, 1'b0, '0, '0);
      exp_q.delete();
      exp_a_rdata = '0;
      exp_b_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- scoreboard / monitor ----------------
   task automatic monitor();
      logic [W-1:0] exp;
      logic [W-1:0] got;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            n_checks++;
            if (ssram_we && ssram_re) begin
               n_fail++; $display("FAIL strobe_excl: ssram_we=%b ssram_re=%b, required not both high", ssram_we, ssram_re);
            end
            n_checks++;
            if (a_ack && b_ack) begin
               n_fail++; $display("FAIL ack_excl: a_ack=%b b_ack=%b, required not both high", a_ack, b_ack);
            end
            n_checks++;
            if ((ssram_we || ssram_re) && dbg_state !== XFER) begin
               n_fail++; $display("FAIL strobe_state: strobe high in state %0d, required state %0d", dbg_state, XFER);
            end
            if (a_ack || b_ack) begin
               got = {b_ack, b_ack ? b_rdata : a_rdata};
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++; $display("FAIL sb_unexpected: ack {port,rdata}=%h, required no ack", got);
               end else begin
                  exp = exp_q.pop_front();
                  if (got !== exp) begin
                     n_fail++; $display("FAIL sb_ack: {port,rdata}=%h, required %h", got, exp);
                  end
               end
            end
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1;
      n_checks++; if ({ssram_we, ssram_re} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: %b, required 00", {ssram_we, ssram_re}); end
      n_checks++; if ({a_ack, b_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: %b, required 00", {a_ack, b_ack}); end
      n_checks++; if ({ssram_addr, ssram_wdata} !== '0) begin n_fail++; $display("FAIL reset_bus: addr=%h wdata=%h, required 0", ssram_addr, ssram_wdata); end
      n_checks++; if ({a_rdata, b_rdata} !== '0) begin n_fail++; $display("FAIL reset_rdata: a=%h b=%h, required 0", a_rdata, b_rdata); end
      n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: %0d, required %0d", dbg_state, IDLE); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_write();
      drive_a(1'b1, 1'b1, 8'h12, 16'hBEEF);
      exp_q.push_back({1'b0, exp_a_rdata});
      @(negedge clk);
      a_req = 1'b0;
      n_checks++; if ({ssram_we, ssram_re} !== 2'b10) begin n_fail++; $display("FAIL wr_strobe: we,re=%b, required 10", {ssram_we, ssram_re}); end
      n_checks++; if (ssram_addr !== 8'h12) begin n_fail++; $display("FAIL wr_addr: %h, required 12", ssram_addr); end
      n_checks++; if (ssram_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_data: %h, required BEEF", ssram_wdata); end
      n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL wr_early_ack: %b, required 0", a_ack); end
      @(negedge clk);
      n_checks++; if ({ssram_we, a_ack, b_ack} !== 3'b010) begin n_fail++; $display("FAIL wr_ack: we,a_ack,b_ack=%b, required 010", {ssram_we, a_ack, b_ack}); end
      @(negedge clk);
      n_checks++; if ({a_ack, dbg_state} !== {1'b0, IDLE}) begin n_fail++; $display("FAIL wr_end: a_ack=%b state=%0d, required 0 and IDLE", a_ack, dbg_state); end
   endtask

   task automatic test_read_b();
      int waited;
      drive_b(1'b1, 1'b0, 8'h34, 16'h0000);
      exp_b_rdata = model_data(8'h34);
      exp_q.push_back({1'b1, exp_b_rdata});
      @(negedge clk);
      b_req = 1'b0;
      n_checks++; if ({ssram_we, ssram_re, ssram_addr} !== {2'b01, 8'h34}) begin n_fail++; $display("FAIL rd_strobe: we,re=%b addr=%h, required 01 and 34", {ssram_we, ssram_re}, ssram_addr); end
      @(negedge clk);
      n_checks++; if ({ssram_re, b_ack, dbg_state} !== {2'b00, RWAIT}) begin n_fail++; $display("FAIL rd_wait: re=%b b_ack=%b state=%0d, required 0,0,RWAIT", ssram_re, b_ack, dbg_state); end
      @(negedge clk);
      n_checks++; if ({b_ack, b_rdata} !== {1'b1, 16'h5A5A}) begin n_fail++; $display("FAIL rd_ack: b_ack=%b b_rdata=%h, required 1 and 5A5A", b_ack, b_rdata); end
      @(negedge clk);
      // A B write must leave b_rdata holding the last read value.
      drive_b(1'b1, 1'b1, 8'h01, 16'($urandom_range(0, 65535)));
      exp_q.push_back({1'b1, exp_b_rdata});
      @(negedge clk);
      b_req = 1'b0;
      waited = 0;
      while (!b_ack && waited < 10) begin @(negedge clk); waited++; end
      n_checks++; if (waited != 1) begin n_fail++; $display("FAIL wr_b_latency: ack after %0d extra cycles, required 1", waited); end
      n_checks++; if (b_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL rdata_hold: %h, required 5A5A", b_rdata); end
      @(negedge clk);
   endtask

   task automatic test_tie();
      logic [DW-1:0] wd;
      do_reset();
      wd = 16'($urandom_range(0, 65535));
      drive_a(1'b1, 1'b1, 8'hA0, wd);
      drive_b(1'b1, 1'b1, 8'hB0, ~wd);
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) exp_q.push_back({1'b0, exp_a_rdata});
         else            exp_q.push_back({1'b1, exp_b_rdata});
      end
      for (int j = 1; j <= 13; j++) begin
         @(negedge clk);
         n_checks++;
         if (a_ack !== (j == 2 || j == 8) || b_ack !== (j == 5 || j == 11)) begin
            n_fail++; $display("FAIL tie_order cycle %0d: a_ack=%b b_ack=%b, required %b %b", j, a_ack, b_ack, (j == 2 || j == 8), (j == 5 || j == 11));
         end
         if (j == 1 || j == 4) begin
            n_checks++;
            if ({ssram_we, ssram_addr} !== {1'b1, (j == 1) ? 8'hA0 : 8'hB0}) begin
               n_fail++; $display("FAIL tie_grant cycle %0d: we=%b addr=%h, required 1 and %h", j, ssram_we, ssram_addr, (j == 1) ? 8'hA0 : 8'hB0);
            end
         end
         if (j == 11) begin
            a_req = 1'b0; b_req = 1'b0;
         end
      end
   endtask

   task automatic test_req_drop();
      int acks = 0;
      logic [AW-1:0] ad;
      ad = 8'($urandom_range(0, 255));
      if (ad == 8'h34) ad = 8'h55;
      drive_a(1'b1, 1'b0, ad, 16'h0000);
      exp_a_rdata = model_data(ad);
      exp_q.push_back({1'b0, exp_a_rdata});
      @(negedge clk);
      drive_a(1'b0, 1'b1, ~ad, 16'hDEAD);
      n_checks++; if ({ssram_re, ssram_addr} !== {1'b1, ad}) begin n_fail++; $display("FAIL drop_latch: re=%b addr=%h, required 1 and %h", ssram_re, ssram_addr, ad); end
      for (int j = 2; j <= 6; j++) begin
         @(negedge clk);
         if (a_ack) acks++;
         n_checks++; if (a_ack !== (j == 3)) begin n_fail++; $display("FAIL drop_ack cycle %0d: %b, required %b", j, a_ack, (j == 3)); end
      end
      n_checks++; if (acks != 1 || a_rdata !== exp_a_rdata) begin n_fail++; $display("FAIL drop_result: acks=%0d rdata=%h, required 1 and %h", acks, a_rdata, exp_a_rdata); end
   endtask

   task automatic test_reset_mid_read();
      drive_b(1'b1, 1'b0, 8'h77, 16'h0000);
      exp_q.push_back({1'b1, model_data(8'h77)});
      @(negedge clk);
      b_req = 1'b0;
      @(negedge clk);
      n_checks++; if (dbg_state !== RWAIT) begin n_fail++; $display("FAIL mid_state: %0d, required RWAIT", dbg_state); end
      #2;
      rst = 1'b0;
      exp_q.delete();
      exp_a_rdata = '0;
      exp_b_rdata = '0;
      #1;
      n_checks++; if ({ssram_we, ssram_re, a_ack, b_ack} !== 4'b0000) begin n_fail++; $display("FAIL mid_async: we,re,a_ack,b_ack=%b, required 0000", {ssram_we, ssram_re, a_ack, b_ack}); end
      n_checks++; if ({a_rdata, b_rdata, dbg_state} !== '0) begin n_fail++; $display("FAIL mid_clear: a=%h b=%h state=%0d, required 0", a_rdata, b_rdata, dbg_state); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         n_checks++;
         if ({a_ack, b_ack, ssram_re, ssram_we} !== 4'b0000 || dbg_state !== IDLE) begin
            n_fail++; $display("FAIL post_reset cycle %0d: ack=%b%b strobes=%b%b state=%0d, required quiet IDLE", j, a_ack, b_ack, ssram_re, ssram_we, dbg_state);
         end
      end
      drive_a(1'b1, 1'b1, 8'h0F, 16'h1357);
      exp_q.push_back({1'b0, exp_a_rdata});
      @(negedge clk);
      a_req = 1'b0;
      @(negedge clk);
      n_checks++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL post_reset_new: a_ack=%b, required 1", a_ack); end
      @(negedge clk);
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single_write();
      test_read_b();
      test_tie();
      test_req_drop();
      test_reset_mid_read();
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
